exu_lsu: RTL and testbench

- Parametrised load/store unit for the execute stage. Replaces the single-request, stall-until-response memory path with a registered request stage and a pending-load queue of depth OUTSTANDING.
- Loads can overlap with each other and with stores.
- Aligns byte lanes and sign/zero-extends load data.
- Writes load results back through its own write-back port; the commit stage arbitrates this port against ALU results.

---
 rtl/exu_lsu_pkg.sv | 44 ++++
 rtl/exu_lsu_pending_fifo.sv | 73 +++++++
 rtl/exu_lsu.sv | 183 ++++++++++++++++++
 tb/tb_exu_lsu.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_lsu_pkg.sv
// Shared definitions for the execute-stage load/store unit: size encodings,
// byte-enable patterns, pending-load metadata and load data alignment.
package exu_lsu_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  localparam int unsigned LSU_RD_W   = 5;
  localparam int unsigned LSU_META_W = 5 + 2 + 2 + 1;

  localparam logic [3:0] LSU_SEL_B = 4'b0001;
  localparam logic [3:0] LSU_SEL_H = 4'b0011;
  localparam logic [3:0] LSU_SEL_W = 4'b1111;

  typedef struct packed {
    logic [LSU_RD_W-1:0] rd;
    logic [1:0]          off;
    logic [1:0]          size;
    logic                uns;
  } lsu_meta_t;

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (size == LSU_SIZE_H) mis = off[0];
    else if (size != LSU_SIZE_B) mis = (off != 2'b00);
    return mis;
  endfunction

  // Select the addressed byte/half from a response word and extend it
  function automatic logic [31:0] lsu_load_align(input lsu_meta_t m, input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {m.off, 3'b000};
    case (m.size)
      LSU_SIZE_B: res = m.uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      LSU_SIZE_H: res = m.uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default:    res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/exu_lsu_pending_fifo.sv
// Generic synchronous FIFO holding metadata of loads awaiting a response.
module lsu_pending_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic             wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
  logic             same_idx;

  assign same_idx = (wr_idx_q == rd_idx_q);
  assign full_o   = same_idx & (wr_wrap_q != rd_wrap_q);
  assign empty_o  = same_idx & (wr_wrap_q == rd_wrap_q);
  assign count_o  = full_o ? CW'(DEPTH) : CW'(AW'(wr_idx_q - rd_idx_q));
  assign rdata_o  = mem_q[rd_idx_q];

  // Indices wrap modulo DEPTH; the wrap bits separate full from empty
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_wrap_d = wr_wrap_q;
    rd_idx_d  = rd_idx_q;
    rd_wrap_d = rd_wrap_q;
    if (push_i) begin
      if (wr_idx_q == AW'(DEPTH-1)) begin
        wr_idx_d  = '0;
        wr_wrap_d = ~wr_wrap_q;
      end else begin
        wr_idx_d = wr_idx_q + AW'(1);
      end
    end
    if (pop_i) begin
      if (rd_idx_q == AW'(DEPTH-1)) begin
        rd_idx_d  = '0;
        rd_wrap_d = ~rd_wrap_q;
      end else begin
        rd_idx_d = rd_idx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_idx_q  <= '0;
      rd_wrap_q <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_wrap_q <= wr_wrap_d;
      rd_idx_q  <= rd_idx_d;
      rd_wrap_q <= rd_wrap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_idx_q] <= wdata_i;
  end

endmodule

// File: rtl/exu_lsu.sv
// Execute-stage load/store unit: registered request stage, pending-load queue
// allowing overlapped loads, lane formatting and registered load write-back.
module exu_lsu
  import exu_lsu_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              store_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        rd_waddr_i,
  output logic              accept_o,
  output logic              hold_flag_o,
  output logic              busy_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_sel_o,
  input  logic              mem_rsp_valid_i,
  output logic              mem_rsp_ready_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_waddr_o,
  output logic [31:0]       wb_wdata_o,
  output logic              misaligned_o,
  output logic [ADDR_W-1:0] misaligned_addr_o
);

  localparam int unsigned CW = $clog2(OUTSTANDING+1);
  localparam int unsigned LW = CW + 1;

  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic              req_we_q, req_we_d;
  logic [3:0]        req_sel_q, req_sel_d;
  lsu_meta_t         req_meta_q, req_meta_d;

  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_waddr_q, wb_waddr_d;
  logic [31:0]       wb_wdata_q, wb_wdata_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] mis_addr_q, mis_addr_d;

  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  lsu_meta_t         head_meta;

  logic              stage_free, push, pop, mis_c, load_ok, take_c;
  logic [3:0]        sel_c;
  logic [31:0]       wdata_c;

  assign stage_free = ~req_valid_q | mem_req_ready_i;
  assign push       = req_valid_q & mem_req_ready_i & ~req_we_q & ~fifo_full;
  assign pop        = mem_rsp_valid_i & mem_rsp_ready_o;
  assign mis_c      = lsu_misaligned(size_i, addr_i[1:0]);

  // Loads count both queued entries and a load still in the request stage
  assign load_ok = (LW'(fifo_count) + LW'(req_valid_q & ~req_we_q) - LW'(pop)) < LW'(OUTSTANDING);

  assign accept_o    = req_i & stage_free & (store_i | mis_c | load_ok);
  assign hold_flag_o = req_i & ~accept_o;
  assign take_c      = accept_o & ~mis_c;

  assign busy_o          = req_valid_q | ~fifo_empty;
  assign mem_rsp_ready_o = ~fifo_empty;

  assign mem_req_valid_o   = req_valid_q;
  assign mem_addr_o        = req_addr_q;
  assign mem_wdata_o       = req_wdata_q;
  assign mem_we_o          = req_we_q;
  assign mem_sel_o         = req_sel_q;
  assign wb_valid_o        = wb_valid_q;
  assign wb_waddr_o        = wb_waddr_q;
  assign wb_wdata_o        = wb_wdata_q;
  assign misaligned_o      = mis_q;
  assign misaligned_addr_o = mis_addr_q;

  // Byte-lane enables and replicated store data
  always_comb begin
    sel_c   = LSU_SEL_W;
    wdata_c = wdata_i;
    case (size_i)
      LSU_SIZE_B: begin
        sel_c   = LSU_SEL_B << addr_i[1:0];
        wdata_c = {4{wdata_i[7:0]}};
      end
      LSU_SIZE_H: begin
        sel_c   = LSU_SEL_H << addr_i[1:0];
        wdata_c = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_we_d    = req_we_q;
    req_sel_d   = req_sel_q;
    req_meta_d  = req_meta_q;
    wb_valid_d  = 1'b0;
    wb_waddr_d  = wb_waddr_q;
    wb_wdata_d  = wb_wdata_q;
    mis_d       = accept_o & mis_c;
    mis_addr_d  = mis_addr_q;

    if (take_c) begin
      req_valid_d     = 1'b1;
      req_addr_d      = {addr_i[ADDR_W-1:2], 2'b00};
      req_wdata_d     = wdata_c;
      req_we_d        = store_i;
      req_sel_d       = sel_c;
      req_meta_d.rd   = rd_waddr_i;
      req_meta_d.off  = addr_i[1:0];
      req_meta_d.size = size_i;
      req_meta_d.uns  = unsigned_i;
    end else if (mem_req_ready_i) begin
      req_valid_d = 1'b0;
    end

    if (accept_o & mis_c) mis_addr_d = addr_i;

    if (pop) begin
      wb_valid_d = (head_meta.rd != 5'd0);
      wb_waddr_d = head_meta.rd;
      wb_wdata_d = lsu_load_align(head_meta, mem_rdata_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_we_q    <= 1'b0;
      req_sel_q   <= '0;
      req_meta_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_waddr_q  <= '0;
      wb_wdata_q  <= '0;
      mis_q       <= 1'b0;
      mis_addr_q  <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_we_q    <= req_we_d;
      req_sel_q   <= req_sel_d;
      req_meta_q  <= req_meta_d;
      wb_valid_q  <= wb_valid_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_wdata_q  <= wb_wdata_d;
      mis_q       <= mis_d;
      mis_addr_q  <= mis_addr_d;
    end
  end

  lsu_pending_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (LSU_META_W)
  ) u_pending (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (req_meta_q),
    .pop_i   (pop),
    .rdata_o (head_meta),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_exu_lsu.sv
// Directed self-checking bench for exu_lsu.
module tb_exu_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, store_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic [4:0]  rd_waddr_i;
  logic        accept_o, hold_flag_o, busy_o;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic        mem_rsp_valid_i, mem_rsp_ready_o;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        misaligned_o;
  logic [31:0] misaligned_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exu_lsu #(.OUTSTANDING(2), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .store_i(store_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_waddr_i(rd_waddr_i),
    .accept_o(accept_o), .hold_flag_o(hold_flag_o), .busy_o(busy_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_sel_o(mem_sel_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_ready_o(mem_rsp_ready_o), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .misaligned_o(misaligned_o), .misaligned_addr_o(misaligned_addr_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    req_i = 1'b1; store_i = st; size_i = sz; unsigned_i = uns;
    addr_i = a; wdata_i = wd; rd_waddr_i = rd;
  endtask

  task automatic idle();
    req_i = 1'b0; store_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = '0; wdata_i = '0; rd_waddr_i = '0;
  endtask

  // Runs one load with a one-cycle response and returns what was observed
  task automatic run_load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          output logic acc, output logic rdy, output logic v,
                          output logic [4:0] wa, output logic [31:0] wd);
    tick();
    drive(1'b0, sz, uns, a, 32'h0, rd);
    #1 acc = accept_o;
    tick();
    idle();
    tick();
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i = rdata;
    #1 rdy = mem_rsp_ready_o;
    tick();
    mem_rsp_valid_i = 1'b0;
    v = wb_valid_o; wa = wb_waddr_o; wd = wb_wdata_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mem_rdata_i = '0;
    #3;
    n_checks++;
    if ({accept_o, hold_flag_o, busy_o, mem_req_valid_o, mem_we_o, mem_rsp_ready_o,
         wb_valid_o, misaligned_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000000", {accept_o, hold_flag_o, busy_o,
               mem_req_valid_o, mem_we_o, mem_rsp_ready_o, wb_valid_o, misaligned_o});
    end
    n_checks++;
    if ({mem_addr_o, mem_wdata_o, mem_sel_o, wb_waddr_o, wb_wdata_o, misaligned_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h sel=%b wb=%h want all zero",
               mem_addr_o, mem_wdata_o, mem_sel_o, wb_wdata_o);
    end
    tick();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_word_load();
    tick();
    drive(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5);
    #1;
    n_checks++;
    if (accept_o !== 1'b1) begin n_fail++; $display("FAIL lw_accept: got %b want 1", accept_o); end
    tick();
    idle();
    n_checks++;
    if ({mem_req_valid_o, mem_we_o, mem_sel_o, mem_addr_o} !== {1'b1, 1'b0, 4'b1111, 32'h100}) begin
      n_fail++;
      $display("FAIL lw_req: got v=%b we=%b sel=%b addr=%h want v=1 we=0 sel=1111 addr=00000100",
               mem_req_valid_o, mem_we_o, mem_sel_o, mem_addr_o);
    end
    tick();
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    #1;
    n_checks++;
    if ({mem_rsp_ready_o, wb_valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL lw_rsp_ready: got rdy=%b wb=%b want rdy=1 wb=0", mem_rsp_ready_o, wb_valid_o);
    end
    tick();
    mem_rsp_valid_i = 1'b0;
    n_checks++;
    if ({wb_valid_o, wb_waddr_o, wb_wdata_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL lw_wb: got v=%b rd=%0d data=%h want v=1 rd=5 data=deadbeef",
               wb_valid_o, wb_waddr_o, wb_wdata_o);
    end
    tick();
    n_checks++;
    if ({wb_valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL lw_done: got wb=%b busy=%b want 0 0", wb_valid_o, busy_o);
    end
  endtask

  task automatic test_subword_load();
    logic [1:0]  sz   [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] addr [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
    logic [31:0] rdat [5] = '{32'h80FFFF7F, 32'h80FFFF7F, 32'h80010000, 32'h1234F00D, 32'h80FFFF7F};
    logic [31:0] exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00D, 32'h0000007F};
    logic acc, rdy, v;
    logic [4:0] wa;
    logic [31:0] wd;
    for (int i = 0; i < 5; i++) begin
      run_load(sz[i], uns[i], addr[i], 5'd9, rdat[i], acc, rdy, v, wa, wd);
      n_checks++;
      if ({acc, v, wa, wd} !== {1'b1, 1'b1, 5'd9, exp[i]}) begin
        n_fail++;
        $display("FAIL subword_%0d: got acc=%b v=%b rd=%0d data=%h want acc=1 v=1 rd=9 data=%h",
                 i, acc, v, wa, wd, exp[i]);
      end
    end
  endtask

  task automatic test_outstanding();
    tick();
    drive(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 5'd1);
    #1;
    n_checks++;
    if (accept_o !== 1'b1) begin n_fail++; $display("FAIL out_acc1: got %b want 1", accept_o); end
    tick();
    drive(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 5'd2);
    #1;
    n_checks++;
    if (accept_o !== 1'b1) begin n_fail++; $display("FAIL out_acc2: got %b want 1", accept_o); end
    tick();
    drive(1'b0, 2'b10, 1'b0, 32'h208, 32'h0, 5'd3);
    #1;
    n_checks++;
    if ({accept_o, hold_flag_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL out_full_hold: got acc=%b hold=%b want acc=0 hold=1", accept_o, hold_flag_o);
    end
    tick();
    n_checks++;
    if ({accept_o, busy_o, mem_req_valid_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL out_full_idle: got acc=%b busy=%b reqv=%b want 0 1 0",
               accept_o, busy_o, mem_req_valid_o);
    end
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i = 32'h11111111;
    #1;
    n_checks++;
    if ({accept_o, mem_rsp_ready_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL out_pop_accept: got acc=%b rdy=%b want 1 1", accept_o, mem_rsp_ready_o);
    end
    tick();
    idle();
    mem_rdata_i = 32'h22222222;
    n_checks++;
    if ({wb_valid_o, wb_waddr_o, wb_wdata_o, mem_req_valid_o, mem_addr_o} !==
        {1'b1, 5'd1, 32'h11111111, 1'b1, 32'h208}) begin
      n_fail++;
      $display("FAIL out_wb1: got v=%b rd=%0d data=%h reqv=%b addr=%h want 1 1 11111111 1 00000208",
               wb_valid_o, wb_waddr_o, wb_wdata_o, mem_req_valid_o, mem_addr_o);
    end
    tick();
    mem_rdata_i = 32'h33333333;
    n_checks++;
    if ({wb_valid_o, wb_waddr_o, wb_wdata_o} !== {1'b1, 5'd2, 32'h22222222}) begin
      n_fail++;
      $display("FAIL out_wb2: got v=%b rd=%0d data=%h want 1 2 22222222", wb_valid_o, wb_waddr_o, wb_wdata_o);
    end
    tick();
    mem_rsp_valid_i = 1'b0;
    n_checks++;
    if ({wb_valid_o, wb_waddr_o, wb_wdata_o} !== {1'b1, 5'd3, 32'h33333333}) begin
      n_fail++;
      $display("FAIL out_wb3: got v=%b rd=%0d data=%h want 1 3 33333333", wb_valid_o, wb_waddr_o, wb_wdata_o);
    end
    tick();
    n_checks++;
    if ({wb_valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL out_drained: got wb=%b busy=%b want 0 0", wb_valid_o, busy_o);
    end
  endtask

  task automatic test_misaligned();
    tick();
    drive(1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, 5'd0);
    #1;
    n_checks++;
    if (accept_o !== 1'b1) begin n_fail++; $display("FAIL mis_accept: got %b want 1", accept_o); end
    tick();
    idle();
    n_checks++;
    if ({misaligned_o, misaligned_addr_o, mem_req_valid_o, busy_o} !== {1'b1, 32'h101, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mis_pulse: got mis=%b addr=%h reqv=%b busy=%b want 1 00000101 0 0",
               misaligned_o, misaligned_addr_o, mem_req_valid_o, busy_o);
    end
    tick();
    n_checks++;
    if (misaligned_o !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle: got %b want 0", misaligned_o); end
    drive(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 5'd4);
    tick();
    idle();
    n_checks++;
    if ({misaligned_o, misaligned_addr_o, mem_req_valid_o, mem_rsp_ready_o} !== {1'b1, 32'h102, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mis_lw: got mis=%b addr=%h reqv=%b rdy=%b want 1 00000102 0 0",
               misaligned_o, misaligned_addr_o, mem_req_valid_o, mem_rsp_ready_o);
    end
    drive(1'b1, 2'b00, 1'b0, 32'h102, 32'h000000AB, 5'd0);
    tick();
    idle();
    n_checks++;
    if ({mem_req_valid_o, mem_we_o, mem_sel_o, mem_wdata_o, mem_addr_o} !==
        {1'b1, 1'b1, 4'b0100, 32'hABABABAB, 32'h100}) begin
      n_fail++;
      $display("FAIL sb_fmt: got v=%b we=%b sel=%b wdata=%h addr=%h want 1 1 0100 abababab 00000100",
               mem_req_valid_o, mem_we_o, mem_sel_o, mem_wdata_o, mem_addr_o);
    end
    drive(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234BEEF, 5'd0);
    tick();
    idle();
    n_checks++;
    if ({mem_sel_o, mem_wdata_o} !== {4'b1100, 32'hBEEFBEEF}) begin
      n_fail++;
      $display("FAIL sh_fmt: got sel=%b wdata=%h want 1100 beefbeef", mem_sel_o, mem_wdata_o);
    end
    tick();
    n_checks++;
    if ({mem_req_valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL store_done: got reqv=%b busy=%b want 0 0", mem_req_valid_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    tick();
    mem_req_ready_i = 1'b0;
    drive(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 5'd0);
    #1;
    n_checks++;
    if (accept_o !== 1'b1) begin n_fail++; $display("FAIL bp_first: got %b want 1", accept_o); end
    tick();
    drive(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({accept_o, hold_flag_o, mem_req_valid_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o} !==
          {1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h300, 32'hCAFEF00D}) begin
        n_fail++;
        $display("FAIL bp_stall_%0d: got acc=%b hold=%b v=%b we=%b sel=%b addr=%h wdata=%h",
                 i, accept_o, hold_flag_o, mem_req_valid_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o);
      end
      tick();
    end
    mem_req_ready_i = 1'b1;
    #1;
    n_checks++;
    if (accept_o !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", accept_o); end
    tick();
    idle();
    n_checks++;
    if ({mem_req_valid_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 32'h304}) begin
      n_fail++;
      $display("FAIL bp_next_load: got v=%b we=%b addr=%h want 1 0 00000304",
               mem_req_valid_o, mem_we_o, mem_addr_o);
    end
    tick();
    n_checks++;
    if ({busy_o, mem_rsp_ready_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL bp_queued: got busy=%b rdy=%b want 1 1", busy_o, mem_rsp_ready_o);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, mem_req_valid_o, mem_rsp_ready_o, wb_valid_o, misaligned_o, mem_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got busy=%b reqv=%b rdy=%b wb=%b mis=%b addr=%h want all 0",
               busy_o, mem_req_valid_o, mem_rsp_ready_o, wb_valid_o, misaligned_o, mem_addr_o);
    end
    tick();
    rst_n = 1'b1;
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i = 32'h55555555;
    #1;
    n_checks++;
    if (mem_rsp_ready_o !== 1'b0) begin n_fail++; $display("FAIL stray_ready: got %b want 0", mem_rsp_ready_o); end
    tick();
    mem_rsp_valid_i = 1'b0;
    n_checks++;
    if ({wb_valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL stray_wb: got wb=%b busy=%b want 0 0", wb_valid_o, busy_o);
    end
  endtask

  task automatic test_x0_load();
    logic acc, rdy, v;
    logic [4:0] wa;
    logic [31:0] wd;
    run_load(2'b10, 1'b0, 32'h400, 5'd0, 32'h12345678, acc, rdy, v, wa, wd);
    n_checks++;
    if ({acc, rdy, v} !== 3'b110) begin
      n_fail++;
      $display("FAIL x0_load: got acc=%b rdy=%b wb=%b want 1 1 0", acc, rdy, v);
    end
    tick();
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL x0_drained: got busy=%b want 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b1, 2'b10, 1'b0, 32'h500 + 32'(4 * i), 32'(i), 5'd0);
      #1;
      n_checks++;
      if (accept_o !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_%0d: got %b want 1", i, accept_o); end
      if (i > 0) begin
        n_checks++;
        if ({mem_req_valid_o, mem_addr_o} !== {1'b1, 32'h500 + 32'(4 * (i - 1))}) begin
          n_fail++;
          $display("FAIL b2b_req_%0d: got v=%b addr=%h want 1 %h", i, mem_req_valid_o, mem_addr_o,
                   32'h500 + 32'(4 * (i - 1)));
        end
      end
    end
    tick();
    idle();
    n_checks++;
    if ({mem_req_valid_o, mem_addr_o} !== {1'b1, 32'h508}) begin
      n_fail++;
      $display("FAIL b2b_last: got v=%b addr=%h want 1 00000508", mem_req_valid_o, mem_addr_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_load();
    test_outstanding();
    test_misaligned();
    test_backpressure();
    test_x0_load();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
